idu_decode_stage: RTL and testbench

Registered RV32I instruction-decode stage with valid/ready handshakes on both sides and a one-entry skid buffer, sitting between the fetch unit and the execute stage of the NPC core. It extends the existing combinational control decode to cover the full RV32I base set: loads, stores, branches, EBREAK and illegal-instruction detection. Address and immediate widths are parameterised. Decode is combinational on the input. Results are registered, so the stage sustains one instruction per cycle under backpressure.

---
 rtl/idu_decode_stage.sv | 389 ++++++++++++++++++++++++++++++++++++++
 tb/tb_idu_decode_stage.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_decode_stage.sv
// idu_decode_stage: registered RV32I decode stage with valid/ready handshakes
// on both sides and a one-entry skid buffer.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous kill of all held instructions
//   in_valid/in_ready     fetch-side handshake; in_inst/in_pc carry the payload
//   out_valid/out_ready   execute-side handshake
//   out_*                 decoded bundle: pc, immediate, register indices,
//                         funct3, ALU controls, write-back select, class flags
//
// Decode is combinational on the fetch payload. The decoded bundle is stored
// in the main register (which drives the outputs) or in the skid register
// when the main register is held by backpressure. Both in_ready and
// out_valid are flops, so out_ready never reaches in_ready combinationally.
module idu_decode_stage #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned ALU_CTRL_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_inst,
   input  logic [XLEN-1:0]       in_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_pc,
   output logic [XLEN-1:0]       out_imm,
   output logic [4:0]            out_rs1,
   output logic [4:0]            out_rs2,
   output logic [4:0]            out_rd,
   output logic [2:0]            out_funct3,
   output logic                  out_reg_write,
   output logic                  out_alu_src,
   output logic                  out_alu_a_pc,
   output logic [ALU_CTRL_W-1:0] out_alu_ctrl,
   output logic [1:0]            out_wb_sel,
   output logic                  out_mem_read,
   output logic                  out_mem_write,
   output logic                  out_branch,
   output logic                  out_is_jal,
   output logic                  out_is_jalr,
   output logic                  out_ebreak,
   output logic                  out_illegal
);

   // Opcodes
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [6:0]  F7_ZERO     = 7'b0000000;
   localparam logic [6:0]  F7_ALT      = 7'b0100000;

   // ALU operation codes
   localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(0);
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(1);
   localparam logic [ALU_CTRL_W-1:0] ALU_AND  = ALU_CTRL_W'(3);
   localparam logic [ALU_CTRL_W-1:0] ALU_OR   = ALU_CTRL_W'(4);
   localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = ALU_CTRL_W'(5);
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = ALU_CTRL_W'(6);
   localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(7);
   localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = ALU_CTRL_W'(8);
   localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = ALU_CTRL_W'(9);
   localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = ALU_CTRL_W'(10);

   // Write-back select
   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_IMM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;
   localparam logic [1:0] WB_MEM = 2'b11;

   // Buffer occupancy states
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   typedef struct packed {
      logic [XLEN-1:0]       pc;
      logic [XLEN-1:0]       imm;
      logic [4:0]            rs1;
      logic [4:0]            rs2;
      logic [4:0]            rd;
      logic [2:0]            funct3;
      logic                  reg_write;
      logic                  alu_src;
      logic                  alu_a_pc;
      logic [ALU_CTRL_W-1:0] alu_ctrl;
      logic [1:0]            wb_sel;
      logic                  mem_read;
      logic                  mem_write;
      logic                  branch;
      logic                  is_jal;
      logic                  is_jalr;
      logic                  ebreak;
      logic                  illegal;
   } bundle_t;

   // Base ALU operation selected by funct3 (OP and OP-IMM share the encoding)
   function automatic logic [ALU_CTRL_W-1:0] alu_of_funct3(input logic [2:0] f3);
      logic [ALU_CTRL_W-1:0] op;
      case (f3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   logic [6:0]      opcode_c;
   logic [2:0]      funct3_c;
   logic [6:0]      funct7_c;
   logic [XLEN-1:0] imm_i_c;
   logic [XLEN-1:0] imm_sh_c;
   logic [XLEN-1:0] imm_s_c;
   logic [XLEN-1:0] imm_b_c;
   logic [XLEN-1:0] imm_u_c;
   logic [XLEN-1:0] imm_j_c;
   logic            ill_c;
   bundle_t         dec_c;

   assign opcode_c = in_inst[6:0];
   assign funct3_c = in_inst[14:12];
   assign funct7_c = in_inst[31:25];

   // Immediate formats, sign-extended to XLEN (shift amount zero-extended)
   assign imm_i_c  = XLEN'($signed(in_inst[31:20]));
   assign imm_sh_c = XLEN'(in_inst[24:20]);
   assign imm_s_c  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
   assign imm_b_c  = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                    in_inst[11:8], 1'b0}));
   assign imm_u_c  = XLEN'($signed({in_inst[31:12], 12'b0}));
   assign imm_j_c  = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                    in_inst[30:21], 1'b0}));

   // Combinational control decode of the offered instruction
   always_comb begin
      dec_c          = '0;
      ill_c          = 1'b0;
      dec_c.pc       = in_pc;
      dec_c.rs1      = in_inst[19:15];
      dec_c.rs2      = in_inst[24:20];
      dec_c.rd       = in_inst[11:7];
      dec_c.funct3   = funct3_c;
      dec_c.alu_ctrl = ALU_ADD;

      case (opcode_c)
         OPC_LUI: begin
            dec_c.imm       = imm_u_c;
            dec_c.reg_write = 1'b1;
            dec_c.alu_src   = 1'b1;
            dec_c.wb_sel    = WB_IMM;
         end
         OPC_AUIPC: begin
            dec_c.imm       = imm_u_c;
            dec_c.reg_write = 1'b1;
            dec_c.alu_src   = 1'b1;
            dec_c.alu_a_pc  = 1'b1;
            dec_c.wb_sel    = WB_ALU;
         end
         OPC_JAL: begin
            dec_c.imm       = imm_j_c;
            dec_c.reg_write = 1'b1;
            dec_c.alu_src   = 1'b1;
            dec_c.alu_a_pc  = 1'b1;
            dec_c.wb_sel    = WB_PC4;
            dec_c.is_jal    = 1'b1;
         end
         OPC_JALR: begin
            dec_c.imm       = imm_i_c;
            dec_c.reg_write = 1'b1;
            dec_c.alu_src   = 1'b1;
            dec_c.wb_sel    = WB_PC4;
            dec_c.is_jalr   = 1'b1;
            ill_c           = (funct3_c != 3'b000);
         end
         OPC_BRANCH: begin
            dec_c.imm      = imm_b_c;
            dec_c.alu_src  = 1'b1;
            dec_c.alu_a_pc = 1'b1;
            dec_c.branch   = 1'b1;
            ill_c          = (funct3_c == 3'b010) || (funct3_c == 3'b011);
         end
         OPC_LOAD: begin
            dec_c.imm       = imm_i_c;
            dec_c.reg_write = 1'b1;
            dec_c.alu_src   = 1'b1;
            dec_c.mem_read  = 1'b1;
            dec_c.wb_sel    = WB_MEM;
            ill_c           = (funct3_c == 3'b011) || (funct3_c[2:1] == 2'b11);
         end
         OPC_STORE: begin
            dec_c.imm       = imm_s_c;
            dec_c.alu_src   = 1'b1;
            dec_c.mem_write = 1'b1;
            ill_c           = (funct3_c > 3'b010);
         end
         OPC_OPIMM: begin
            dec_c.reg_write = 1'b1;
            dec_c.alu_src   = 1'b1;
            dec_c.wb_sel    = WB_ALU;
            dec_c.alu_ctrl  = alu_of_funct3(funct3_c);
            if (funct3_c == 3'b001) begin
               dec_c.imm = imm_sh_c;
               ill_c     = (funct7_c != F7_ZERO);
            end else if (funct3_c == 3'b101) begin
               dec_c.imm = imm_sh_c;
               if (funct7_c == F7_ALT) begin
                  dec_c.alu_ctrl = ALU_SRA;
               end else begin
                  ill_c = (funct7_c != F7_ZERO);
               end
            end else begin
               dec_c.imm = imm_i_c;
            end
         end
         OPC_OP: begin
            dec_c.reg_write = 1'b1;
            dec_c.wb_sel    = WB_ALU;
            dec_c.alu_ctrl  = alu_of_funct3(funct3_c);
            // funct7=0100000 only selects SUB or SRA
            if (funct7_c == F7_ALT) begin
               if (funct3_c == 3'b000) begin
                  dec_c.alu_ctrl = ALU_SUB;
               end else if (funct3_c == 3'b101) begin
                  dec_c.alu_ctrl = ALU_SRA;
               end else begin
                  ill_c = 1'b1;
               end
            end else begin
               ill_c = (funct7_c != F7_ZERO);
            end
         end
         OPC_SYSTEM: begin
            if (in_inst == INST_EBREAK) begin
               dec_c.ebreak = 1'b1;
            end else begin
               ill_c = 1'b1;
            end
         end
         default: ill_c = 1'b1;
      endcase

      // Illegal instructions carry no side effects downstream
      if (ill_c) begin
         dec_c.reg_write = 1'b0;
         dec_c.alu_src   = 1'b0;
         dec_c.alu_a_pc  = 1'b0;
         dec_c.alu_ctrl  = ALU_ADD;
         dec_c.wb_sel    = WB_ALU;
         dec_c.mem_read  = 1'b0;
         dec_c.mem_write = 1'b0;
         dec_c.branch    = 1'b0;
         dec_c.is_jal    = 1'b0;
         dec_c.is_jalr   = 1'b0;
         dec_c.illegal   = 1'b1;
      end

      // x0 is never written
      if (dec_c.rd == 5'd0) begin
         dec_c.reg_write = 1'b0;
      end
   end

   logic [1:0] state;
   logic [1:0] state_nxt_c;
   logic       accept_c;
   logic       drain_c;
   logic       load_m_dec_c;
   logic       load_m_skid_c;
   logic       load_s_c;
   bundle_t    m_q;
   bundle_t    s_q;

   assign accept_c = in_valid & in_ready;
   assign drain_c  = out_valid & out_ready;

   // Occupancy state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt_c;
      end
   end

   // Next occupancy and register load selects
   always_comb begin
      state_nxt_c   = state;
      load_m_dec_c  = 1'b0;
      load_m_skid_c = 1'b0;
      load_s_c      = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (accept_c) begin
               state_nxt_c  = ST_ONE;
               load_m_dec_c = 1'b1;
            end
         end
         ST_ONE: begin
            if (accept_c && !drain_c) begin
               state_nxt_c = ST_TWO;
               load_s_c    = 1'b1;
            end else if (accept_c && drain_c) begin
               load_m_dec_c = 1'b1;
            end else if (drain_c) begin
               state_nxt_c = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (drain_c) begin
               state_nxt_c   = ST_ONE;
               load_m_skid_c = 1'b1;
            end
         end
         default: state_nxt_c = ST_EMPTY;
      endcase
      // A redirect discards everything, including this cycle's offer
      if (flush) begin
         state_nxt_c   = ST_EMPTY;
         load_m_dec_c  = 1'b0;
         load_m_skid_c = 1'b0;
         load_s_c      = 1'b0;
      end
   end

   // Handshake flops follow the next occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         out_valid <= (state_nxt_c != ST_EMPTY);
         in_ready  <= (state_nxt_c != ST_TWO);
      end
   end

   // Main and skid payload registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q <= '0;
         s_q <= '0;
      end else begin
         if (load_m_dec_c) begin
            m_q <= dec_c;
         end else if (load_m_skid_c) begin
            m_q <= s_q;
         end
         if (load_s_c) begin
            s_q <= dec_c;
         end
      end
   end

   assign out_pc        = m_q.pc;
   assign out_imm       = m_q.imm;
   assign out_rs1       = m_q.rs1;
   assign out_rs2       = m_q.rs2;
   assign out_rd        = m_q.rd;
   assign out_funct3    = m_q.funct3;
   assign out_reg_write = m_q.reg_write;
   assign out_alu_src   = m_q.alu_src;
   assign out_alu_a_pc  = m_q.alu_a_pc;
   assign out_alu_ctrl  = m_q.alu_ctrl;
   assign out_wb_sel    = m_q.wb_sel;
   assign out_mem_read  = m_q.mem_read;
   assign out_mem_write = m_q.mem_write;
   assign out_branch    = m_q.branch;
   assign out_is_jal    = m_q.is_jal;
   assign out_is_jalr   = m_q.is_jalr;
   assign out_ebreak    = m_q.ebreak;
   assign out_illegal   = m_q.illegal;

endmodule

// File: tb/tb_idu_decode_stage.sv
// Scoreboard bench for idu_decode_stage: directed instructions push their
// hand-computed bundles into a queue; a monitor pops and compares on every
// execute-side handshake. A second XLEN=64 instance checks wide immediates.
module tb_idu_decode_stage;

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic        reg_write;
      logic        alu_src;
      logic        alu_a_pc;
      logic [3:0]  alu_ctrl;
      logic [1:0]  wb_sel;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        is_jal;
      logic        is_jalr;
      logic        ebreak;
      logic        illegal;
   } exp_t;

   logic            clk;
   logic            rst_n;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic [XLEN-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_imm;
   logic [4:0]      out_rs1, out_rs2, out_rd;
   logic [2:0]      out_funct3;
   logic            out_reg_write, out_alu_src, out_alu_a_pc;
   logic [AW-1:0]   out_alu_ctrl;
   logic [1:0]      out_wb_sel;
   logic            out_mem_read, out_mem_write, out_branch;
   logic            out_is_jal, out_is_jalr, out_ebreak, out_illegal;

   idu_decode_stage #(.XLEN(XLEN), .ALU_CTRL_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_imm(out_imm),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_funct3(out_funct3), .out_reg_write(out_reg_write),
      .out_alu_src(out_alu_src), .out_alu_a_pc(out_alu_a_pc),
      .out_alu_ctrl(out_alu_ctrl), .out_wb_sel(out_wb_sel),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_branch(out_branch), .out_is_jal(out_is_jal), .out_is_jalr(out_is_jalr),
      .out_ebreak(out_ebreak), .out_illegal(out_illegal)
   );

   // XLEN=64 instance
   logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
   logic [31:0] w_in_inst;
   logic [63:0] w_in_pc, w_out_pc, w_out_imm;
   logic [4:0]  w_rs1, w_rs2, w_rd;
   logic [2:0]  w_funct3;
   logic        w_reg_write, w_alu_src, w_alu_a_pc;
   logic [AW-1:0] w_alu_ctrl;
   logic [1:0]  w_wb_sel;
   logic        w_mem_read, w_mem_write, w_branch, w_jal, w_jalr, w_ebreak, w_illegal;

   idu_decode_stage #(.XLEN(64), .ALU_CTRL_W(AW)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(w_in_valid), .in_ready(w_in_ready), .in_inst(w_in_inst), .in_pc(w_in_pc),
      .out_valid(w_out_valid), .out_ready(w_out_ready),
      .out_pc(w_out_pc), .out_imm(w_out_imm),
      .out_rs1(w_rs1), .out_rs2(w_rs2), .out_rd(w_rd),
      .out_funct3(w_funct3), .out_reg_write(w_reg_write),
      .out_alu_src(w_alu_src), .out_alu_a_pc(w_alu_a_pc),
      .out_alu_ctrl(w_alu_ctrl), .out_wb_sel(w_wb_sel),
      .out_mem_read(w_mem_read), .out_mem_write(w_mem_write),
      .out_branch(w_branch), .out_is_jal(w_jal), .out_is_jalr(w_jalr),
      .out_ebreak(w_ebreak), .out_illegal(w_illegal)
   );

   int   checks   = 0;
   int   failures = 0;
   exp_t q[$];
   exp_t act;

   assign act = {out_pc, out_imm, out_rs1, out_rs2, out_rd, out_funct3,
                 out_reg_write, out_alu_src, out_alu_a_pc, out_alu_ctrl,
                 out_wb_sel, out_mem_read, out_mem_write, out_branch,
                 out_is_jal, out_is_jalr, out_ebreak, out_illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] imm,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [2:0] f3,
                               input logic rw, input logic src, input logic apc,
                               input logic [3:0] ctrl, input logic [1:0] wb,
                               input logic mr, input logic mw, input logic br,
                               input logic jal, input logic jalr,
                               input logic eb, input logic ill);
      exp_t e;
      e.pc = pc; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.funct3 = f3;
      e.reg_write = rw; e.alu_src = src; e.alu_a_pc = apc; e.alu_ctrl = ctrl;
      e.wb_sel = wb; e.mem_read = mr; e.mem_write = mw; e.branch = br;
      e.is_jal = jal; e.is_jalr = jalr; e.ebreak = eb; e.illegal = ill;
      return e;
   endfunction

   // addi x1,x0,5 at a given pc
   function automatic exp_t addi5(input logic [31:0] pc);
      return mk(pc, 32'd5, 5'd0, 5'd5, 5'd1, 3'd0, 1, 1, 0, 4'd0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   // Monitor: compare every handshake against the queue, and check hold stability
   initial begin
      exp_t prev;
      exp_t e;
      bit   hold;
      hold = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold = 1'b0;
         end else begin
            if (hold && out_valid) begin
               checks++;
               if (act !== prev) begin
                  failures++;
                  $display("FAIL hold_stable actual=%h expected=%h", act, prev);
               end
            end
            if (out_valid && out_ready) begin
               checks++;
               if (q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_output actual=%h expected=none", act);
               end else begin
                  e = q.pop_front();
                  if (act !== e) begin
                     failures++;
                     $display("FAIL bundle pc=%h actual=%h expected=%h", e.pc, act, e);
                  end
               end
            end
            hold = out_valid && !out_ready;
            prev = act;
         end
      end
   end

   // Offer one instruction until accepted; its expectation is queued on acceptance
   task automatic issue(input logic [31:0] inst, input exp_t e);
      int  n;
      bit  done;
      n = 0;
      done = 1'b0;
      in_valid = 1'b1;
      in_inst  = inst;
      in_pc    = e.pc;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            q.push_back(e);
            done = 1'b1;
         end else if (++n > 50) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout pc=%h actual=stalled expected=accepted", e.pc);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
      w_in_valid = 1'b0; w_in_inst = '0; w_in_pc = '0; w_out_ready = 1'b1;

      // Reset state
      #12;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_pc", 64'(out_pc), 64'd0);
      chk("rst_out_imm", 64'(out_imm), 64'd0);
      chk("rst_reg_write", 64'(out_reg_write), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // XLEN=64: lui sign-extension, then addi x0 never writes
      w_in_valid = 1'b1; w_in_inst = 32'h800000B7;
      @(posedge clk); #1;
      w_in_inst = 32'h00100013;
      @(negedge clk);
      chk("x64_lui_valid", 64'(w_out_valid), 64'd1);
      chk("x64_lui_imm", w_out_imm, 64'hFFFFFFFF80000000);
      chk("x64_lui_reg_write", 64'(w_reg_write), 64'd1);
      @(posedge clk); #1;
      w_in_valid = 1'b0;
      @(negedge clk);
      chk("x64_addi_x0_imm", w_out_imm, 64'd1);
      chk("x64_addi_x0_reg_write", 64'(w_reg_write), 64'd0);
      @(posedge clk); #1;

      // First instruction latency
      out_ready = 1'b1;
      issue(32'h00500093, addi5(32'h100));
      @(negedge clk);
      chk("latency_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;

      // Back-to-back stream with out_ready high
      issue(32'hFE20CEE3, mk(32'h104, 32'hFFFFFFFC, 1, 2, 29, 3'd4, 0, 1, 1, 4'd0, 2'b00, 0, 0, 1, 0, 0, 0, 0));
      issue(32'h00112423, mk(32'h108, 32'd8, 2, 1, 8, 3'd2, 0, 1, 0, 4'd0, 2'b00, 0, 1, 0, 0, 0, 0, 0));
      issue(32'h40005013, mk(32'h10C, 32'd0, 0, 0, 0, 3'd5, 0, 1, 0, 4'd10, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      issue(32'h02005013, mk(32'h110, 32'd0, 0, 0, 0, 3'd5, 0, 0, 0, 4'd0, 2'b00, 0, 0, 0, 0, 0, 0, 1));
      issue(32'h00100073, mk(32'h114, 32'd0, 0, 1, 0, 3'd0, 0, 0, 0, 4'd0, 2'b00, 0, 0, 0, 0, 0, 1, 0));
      issue(32'h002081B3, mk(32'h118, 32'd0, 1, 2, 3, 3'd0, 1, 0, 0, 4'd0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      issue(32'h40208233, mk(32'h11C, 32'd0, 1, 2, 4, 3'd0, 1, 0, 0, 4'd1, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      issue(32'hFFC0A283, mk(32'h120, 32'hFFFFFFFC, 1, 28, 5, 3'd2, 1, 1, 0, 4'd0, 2'b11, 1, 0, 0, 0, 0, 0, 0));
      issue(32'h008000EF, mk(32'h124, 32'd8, 0, 8, 1, 3'd0, 1, 1, 1, 4'd0, 2'b10, 0, 0, 0, 1, 0, 0, 0));
      issue(32'h800000B7, mk(32'h128, 32'h80000000, 0, 0, 1, 3'd0, 1, 1, 0, 4'd0, 2'b01, 0, 0, 0, 0, 0, 0, 0));
      issue(32'hFFFFFFFF, mk(32'h12C, 32'd0, 31, 31, 31, 3'd7, 0, 0, 0, 4'd0, 2'b00, 0, 0, 0, 0, 0, 0, 1));
      @(negedge clk); #1;
      chk("stream_drained", 64'(q.size()), 64'd0);
      @(posedge clk); #1;

      // Backpressure: two accepted, third stalls, then all drain in order
      out_ready = 1'b0;
      issue(32'h00500093, addi5(32'h200));
      issue(32'h00500093, addi5(32'h204));
      in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h208;
      @(negedge clk);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      fork
         issue(32'h00500093, addi5(32'h208));
         begin
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (3) @(negedge clk);
      #1;
      chk("bp_drained", 64'(q.size()), 64'd0);
      @(posedge clk); #1;

      // Flush in state TWO with an instruction offered
      out_ready = 1'b0;
      issue(32'h00500093, addi5(32'h300));
      issue(32'h00500093, addi5(32'h304));
      flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h308;
      @(negedge clk);
      q.delete();
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      issue(32'h00500093, addi5(32'h30C));
      repeat (2) @(negedge clk);
      #1;
      chk("flush_after_drained", 64'(q.size()), 64'd0);
      @(posedge clk); #1;

      // Asynchronous reset mid-operation
      out_ready = 1'b0;
      issue(32'h00500093, addi5(32'h400));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      issue(32'h00500093, addi5(32'h404));
      repeat (2) @(negedge clk);
      #1;
      chk("midrst_drained", 64'(q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
